// File: rtl/c_tile_streamer.sv
// Row-major streamer for a completed C tile: reads each element through the SRAM
// controller port and re-emits it on a valid/ready stream. Optional macro: C_STREAM_ROWMAX_EN.
module c_tile_streamer #(
  parameter int M      = 8,
  parameter int N      = 8,
  parameter int DATA_W = 32,
  parameter int ROW_W  = (M <= 1) ? 1 : $clog2(M),
  parameter int COL_W  = (N <= 1) ? 1 : $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              abort,
  input  logic              c_valid_in,
  output logic              rd_en,
  output logic              rd_re,
  output logic [ROW_W-1:0]  rd_row,
  output logic [COL_W-1:0]  rd_col,
  input  logic [DATA_W-1:0] rd_rdata,
  input  logic              rd_rvalid,
  output logic              s_valid,
  input  logic              s_ready,
  output logic [DATA_W-1:0] s_data,
  output logic [ROW_W-1:0]  s_row,
  output logic [COL_W-1:0]  s_col,
  output logic              s_last_col,
  output logic              s_last,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] row_max,
  output logic              row_max_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, OUT} state_t;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(M - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(N - 1);

  state_t              r_state;
  logic [ROW_W-1:0]    r_row;
  logic [COL_W-1:0]    r_col;
  logic                r_sValid;
  logic [DATA_W-1:0]   r_sData;
  logic [ROW_W-1:0]    r_sRow;
  logic [COL_W-1:0]    r_sCol;
  logic                r_sLastCol;
  logic                r_sLast;
  logic                r_done;

  logic w_lastCol;
  logic w_lastRow;
  logic w_inReq;
  logic w_abortNow;
  logic w_capture;
  logic w_handshake;

  assign w_lastCol   = (r_col == LAST_COL);
  assign w_lastRow   = (r_row == LAST_ROW);
  assign w_inReq     = (r_state == REQ);
  assign w_abortNow  = abort && (r_state != IDLE);
  assign w_capture   = (r_state == WAIT_RD) && rd_rvalid;
  assign w_handshake = (r_state == OUT) && s_ready;

  // The request is only ever raised in REQ, so a single read is in flight at a time.
  assign rd_en  = w_inReq && c_valid_in;
  assign rd_re  = rd_en;
  assign rd_row = w_inReq ? r_row : '0;
  assign rd_col = w_inReq ? r_col : '0;

  assign busy       = (r_state != IDLE);
  assign done       = r_done;
  assign s_valid    = r_sValid;
  assign s_data     = r_sData;
  assign s_row      = r_sRow;
  assign s_col      = r_sCol;
  assign s_last_col = r_sLastCol;
  assign s_last     = r_sLast;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_sValid   <= 1'b0;
      r_sData    <= '0;
      r_sRow     <= '0;
      r_sCol     <= '0;
      r_sLastCol <= 1'b0;
      r_sLast    <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // Abort beats a same-cycle handshake, so a cancelled tile never reports done.
      if (w_abortNow) begin
        r_state  <= IDLE;
        r_sValid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (go) begin
              r_row   <= '0;
              r_col   <= '0;
              r_state <= REQ;
            end
          end
          REQ: begin
            if (c_valid_in) begin
              r_state <= WAIT_RD;
            end
          end
          WAIT_RD: begin
            if (rd_rvalid) begin
              r_sData    <= rd_rdata;
              r_sRow     <= r_row;
              r_sCol     <= r_col;
              r_sLastCol <= w_lastCol;
              r_sLast    <= w_lastCol && w_lastRow;
              r_sValid   <= 1'b1;
              r_state    <= OUT;
            end
          end
          OUT: begin
            if (s_ready) begin
              r_sValid <= 1'b0;
              if (r_sLast) begin
                r_state <= IDLE;
                r_done  <= 1'b1;
              end else begin
                if (w_lastCol) begin
                  r_col <= '0;
                  r_row <= r_row + ROW_W'(1);
                end else begin
                  r_col <= r_col + COL_W'(1);
                end
                r_state <= REQ;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef C_STREAM_ROWMAX_EN
  // Sign-magnitude floats become monotonic unsigned keys; -0.0 sorts just below +0.0.
  function automatic logic [DATA_W-1:0] orderKey(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? ~x : (x ^ {1'b1, {(DATA_W-1){1'b0}}});
  endfunction

  logic [DATA_W-1:0] r_runMax;
  logic [DATA_W-1:0] r_rowMax;
  logic              r_rowMaxValid;
  logic [DATA_W-1:0] w_newMax;

  always_comb begin
    w_newMax = rd_rdata;
    if ((r_col != '0) && (orderKey(r_runMax) >= orderKey(rd_rdata))) begin
      w_newMax = r_runMax;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_runMax      <= '0;
      r_rowMax      <= '0;
      r_rowMaxValid <= 1'b0;
    end else if (w_abortNow) begin
      r_rowMaxValid <= 1'b0;
    end else if (w_capture) begin
      r_runMax      <= w_newMax;
      r_rowMaxValid <= w_lastCol;
      if (w_lastCol) begin
        r_rowMax <= w_newMax;
      end
    end else if (w_handshake) begin
      r_rowMaxValid <= 1'b0;
    end
  end

  assign row_max       = r_rowMax;
  assign row_max_valid = r_rowMaxValid;
`else
  assign row_max       = '0;
  assign row_max_valid = 1'b0;
`endif

endmodule

// File: tb/tb_c_tile_streamer.sv
// Randomized bench for c_tile_streamer: a latency-varying controller model and a
// row-major reference stream check every beat, request address and done pulse.
module tb_c_tile_streamer;

  localparam int M  = 3;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int RW = 2;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst, go, abort, c_valid_in, rd_rvalid, s_ready;
  logic [DW-1:0] rd_rdata;
  logic          rd_en, rd_re, s_valid, s_last_col, s_last, busy, done, row_max_valid;
  logic [RW-1:0] rd_row, s_row;
  logic [CW-1:0] rd_col, s_col;
  logic [DW-1:0] s_data, row_max;

  c_tile_streamer #(.M(M), .N(N), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .go(go), .abort(abort), .c_valid_in(c_valid_in),
    .rd_en(rd_en), .rd_re(rd_re), .rd_row(rd_row), .rd_col(rd_col),
    .rd_rdata(rd_rdata), .rd_rvalid(rd_rvalid),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_row(s_row), .s_col(s_col),
    .s_last_col(s_last_col), .s_last(s_last), .busy(busy), .done(done),
    .row_max(row_max), .row_max_valid(row_max_valid)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Tile contents and controller model state
  logic [DW-1:0] mem [M][N];
  bit   pend = 0;
  int   pendCnt = 0;
  int   pRow = 0, pCol = 0;
  int   latency = 2;
  bit   randLat = 0;
  bit   spurious = 0;
  bit   randReady = 0;
  bit   randCvalid = 0;

  // Reference stream bookkeeping
  int   tileBeats = 0;
  int   doneCount = 0;
  bit   prevLastHs = 0;
  bit   prevStall = 0;
  logic [63:0] prevPayload;
  logic [DW-1:0] prevRowMax;
  int   monRow, monCol;
  logic [DW-1:0] refMax;

  function automatic logic [31:0] floatKey(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

  // Controller: one read in flight, rvalid 'latency' cycles after the request cycle
  always @(negedge clk) begin
    rd_rvalid = 1'b0;
    if (rst) begin
      pend = 0;
    end else begin
      if (pend) begin
        pendCnt--;
        if (pendCnt == 0) begin
          rd_rvalid = 1'b1;
          rd_rdata  = mem[pRow][pCol];
          pend      = 0;
        end
      end else if (spurious && s_valid) begin
        rd_rvalid = 1'b1;
        rd_rdata  = 32'hDEAD_BEEF;
        spurious  = 0;
      end
      if (rd_en) begin
        if (pend) checkOutput("second_outstanding_read", 1, 0);
        checkOutput("rd_re_eq_rd_en", rd_re, 1);
        checkOutput("rd_row", rd_row, tileBeats / N);
        checkOutput("rd_col", rd_col, tileBeats % N);
        pend    = 1;
        pendCnt = randLat ? $urandom_range(1, 3) : latency;
        pRow    = rd_row;
        pCol    = rd_col;
      end
    end
  end

  // Stream monitor against the row-major reference order
  always @(negedge clk) begin
    if (rst) begin
      prevLastHs = 0;
      prevStall  = 0;
    end else begin
      if (prevLastHs || done) checkOutput("done_pulse", done, prevLastHs);
      if (done) begin
        doneCount++;
        checkOutput("busy_low_at_done", busy, 0);
      end
      prevLastHs = 0;
      if (prevStall) begin
        checkOutput("hold_valid", s_valid, 1);
        checkOutput("hold_payload", {row_max_valid, s_data, s_row, s_col, s_last_col, s_last}, prevPayload);
        checkOutput("hold_row_max", row_max, prevRowMax);
      end
      prevStall = 0;
      if (rd_en && s_valid) checkOutput("request_while_beat_pending", 1, 0);
      if (s_valid && !abort) begin
        if (s_ready) begin
          monRow = tileBeats / N;
          monCol = tileBeats % N;
          checkOutput("beat_row", s_row, monRow);
          checkOutput("beat_col", s_col, monCol);
          checkOutput("beat_data", s_data, mem[monRow][monCol]);
          checkOutput("beat_last_col", s_last_col, monCol == N - 1);
          checkOutput("beat_last", s_last, (monRow == M - 1) && (monCol == N - 1));
`ifdef C_STREAM_ROWMAX_EN
          checkOutput("row_max_valid", row_max_valid, monCol == N - 1);
          if (monCol == N - 1) begin
            refMax = mem[monRow][0];
            for (int k = 1; k < N; k++)
              if (floatKey(mem[monRow][k]) > floatKey(refMax)) refMax = mem[monRow][k];
            checkOutput("row_max", row_max, refMax);
          end
`else
          checkOutput("row_max_tied", {row_max_valid, row_max}, 0);
`endif
          tileBeats++;
          prevLastHs = (monRow == M - 1) && (monCol == N - 1);
        end else begin
          prevStall   = 1;
          prevPayload = {row_max_valid, s_data, s_row, s_col, s_last_col, s_last};
          prevRowMax  = row_max;
        end
      end
    end
  end

  // Random backpressure and controller availability
  always @(posedge clk) begin
    #1;
    if (randReady)  s_ready    = ($urandom_range(0, 99) < 60);
    if (randCvalid) c_valid_in = ($urandom_range(0, 99) < 70);
  end

  task automatic fillMem();
    for (int r = 0; r < M; r++)
      for (int c = 0; c < N; c++)
        mem[r][c] = $urandom;
  endtask

  task automatic pulseGo();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic waitDone(input int prevDone, input string tag);
    int n = 0;
    while (doneCount == prevDone && n < 3000) begin
      tick();
      n++;
    end
    if (doneCount == prevDone) checkOutput(tag, 0, 1);
  endtask

  // One full tile under the current knobs; checks beat and done counts
  task automatic applyStimulus(input string tag);
    int d0;
    d0 = doneCount;
    tileBeats = 0;
    pulseGo();
    waitDone(d0, {tag, "_timeout"});
    checkOutput({tag, "_beats"}, tileBeats, M * N);
    checkOutput({tag, "_done_count"}, doneCount, d0 + 1);
  endtask

  initial begin
    int cycles;
    int d0;
    int n;
    rst = 1'b1; go = 1'b0; abort = 1'b0; c_valid_in = 1'b0; s_ready = 1'b0;
    rd_rvalid = 1'b0; rd_rdata = '0;
    fillMem();
    repeat (3) tick();

    checkOutput("rst_rd_en", {rd_en, rd_re}, 0);
    checkOutput("rst_rd_addr", {rd_row, rd_col}, 0);
    checkOutput("rst_s_valid", s_valid, 0);
    checkOutput("rst_s_data", s_data, 0);
    checkOutput("rst_s_rowcol", {s_row, s_col}, 0);
    checkOutput("rst_flags", {s_last_col, s_last}, 0);
    checkOutput("rst_busy_done", {busy, done}, 0);
    checkOutput("rst_row_max", {row_max_valid, row_max}, 0);
    rst = 1'b0;
    tick();

    $display("[TB] fixed latency 2, always ready: throughput");
    c_valid_in = 1'b1; s_ready = 1'b1; latency = 2;
    tileBeats = 0;
    d0 = doneCount;
    go = 1'b1;
    tick();
    go = 1'b0;
    checkOutput("first_req_after_go", {rd_en, rd_row, rd_col}, {1'b1, 4'd0});
    cycles = 1;
    while (!done && cycles < 500) begin
      tick();
      cycles++;
    end
    checkOutput("tile_latency_cycles", cycles, (latency + 2) * M * N + 1);
    tick();
    checkOutput("fixed_beats", tileBeats, M * N);
    checkOutput("fixed_done_count", doneCount, d0 + 1);

    $display("[TB] abort ignored while idle");
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("idle_abort_busy", busy, 0);

    $display("[TB] c_valid_in held low after go");
    fillMem();
    c_valid_in = 1'b0;
    tileBeats = 0;
    d0 = doneCount;
    pulseGo();
    for (int i = 0; i < 10; i++) begin
      checkOutput("no_req_without_cvalid", rd_en, 0);
      checkOutput("busy_waiting_cvalid", busy, 1);
      tick();
    end
    c_valid_in = 1'b1;
    #1;
    checkOutput("req_when_cvalid_rises", {rd_en, rd_row, rd_col}, {1'b1, 4'd0});
    waitDone(d0, "cvalid_timeout");
    checkOutput("cvalid_beats", tileBeats, M * N);

    $display("[TB] stall on first beat, then random backpressure");
    fillMem();
    s_ready = 1'b0;
    tileBeats = 0;
    d0 = doneCount;
    pulseGo();
    n = 0;
    while (!s_valid && n < 20) begin
      tick();
      n++;
    end
    checkOutput("first_beat_arrives", s_valid, 1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("no_req_during_stall", rd_en, 0);
      tick();
    end
    s_ready = 1'b1;
    tick();
    checkOutput("req_right_after_handshake", {s_valid, rd_en}, 2'b01);
    randLat = 1; randReady = 1; randCvalid = 1;
    waitDone(d0, "random_timeout");
    checkOutput("random_beats", tileBeats, M * N);
    randReady = 0; randCvalid = 0; randLat = 0;
    s_ready = 1'b1; c_valid_in = 1'b1;
    tick();

    $display("[TB] abort while waiting for element (1,0)");
    fillMem();
    latency = 3;
    tileBeats = 0;
    d0 = doneCount;
    pulseGo();
    n = 0;
    while (!(rd_en && rd_row == 1 && rd_col == 0) && n < 200) begin
      tick();
      n++;
    end
    checkOutput("reached_row1_request", {rd_en, rd_row, rd_col}, {1'b1, 2'd1, 2'd0});
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_s_valid", s_valid, 0);
    repeat (8) tick();
    checkOutput("abort_no_more_beats", tileBeats, N);
    checkOutput("abort_no_done", doneCount, d0);
    checkOutput("abort_stays_idle", {busy, s_valid}, 0);
    latency = 2;
    applyStimulus("restart_after_abort");

    $display("[TB] go while busy and spurious rvalid");
    fillMem();
    s_ready = 1'b0;
    tileBeats = 0;
    d0 = doneCount;
    pulseGo();
    n = 0;
    while (!s_valid && n < 20) begin
      tick();
      n++;
    end
    spurious = 1;
    repeat (2) tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    s_ready = 1'b1;
    waitDone(d0, "busy_go_timeout");
    checkOutput("busy_go_beats", tileBeats, M * N);
    repeat (3) tick();
    checkOutput("busy_go_single_done", doneCount, d0 + 1);
    checkOutput("busy_go_ends_idle", busy, 0);

    $display("[TB] row maximum with signed zeros");
    fillMem();
    mem[0][0] = 32'hBF80_0000;
    mem[0][1] = 32'h8000_0000;
    mem[0][2] = 32'h0000_0000;
    mem[0][3] = 32'hC060_0000;
    mem[1][2] = 32'h7FC0_0000;
    randReady = 1; randLat = 1;
    applyStimulus("rowmax_tile");
    randReady = 0; randLat = 0;
    s_ready = 1'b1;

    $display("[TB] reset mid-stream");
    fillMem();
    tileBeats = 0;
    pulseGo();
    repeat (9) tick();
    rst = 1'b1;
    tick();
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_stream", {s_valid, s_data, s_row, s_col, s_last_col, s_last}, 0);
    checkOutput("midrst_req", {rd_en, rd_row, rd_col}, 0);
    checkOutput("midrst_done", done, 0);
    rst = 1'b0;
    repeat (2) tick();
    applyStimulus("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
